// File: rtl/bus_des_pkg.sv
// Shared bus field layout and deserializer state encoding.
// Used by both the SER and DES ends of the 73-bit bus.
package bus_des_pkg;

  localparam int unsigned BUS_W   = 73;
  localparam int unsigned CHUNK_W = 32;
  localparam int unsigned NCHUNK  = 4;

  localparam int unsigned VALID   = 0;
  localparam int unsigned PADR_LO = 1;
  localparam int unsigned PADR_HI = 15;
  localparam int unsigned DATA_LO = 16;
  localparam int unsigned DATA_HI = 47;
  localparam int unsigned RET_LO  = 48;
  localparam int unsigned RET_HI  = 51;
  localparam int unsigned DEST_LO = 52;
  localparam int unsigned DEST_HI = 55;
  localparam int unsigned RW      = 56;
  localparam int unsigned SIZE_LO = 57;
  localparam int unsigned SIZE_HI = 60;

  localparam int unsigned PADR_W  = PADR_HI - PADR_LO + 1;
  localparam int unsigned SIZE_W  = SIZE_HI - SIZE_LO + 1;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StFull
  } des_state_e;

endpackage

// File: rtl/bus_des_if.sv
// Bus-side and block-side signals of one deserializing endpoint.
// slave is the receiver's view; master is the bus/block environment's view.
interface bus_des_if;

  logic [bus_des_pkg::BUS_W-1:0]                        BUS;
  logic                                                 free_bau;
  logic                                                 valid_out;
  logic [bus_des_pkg::PADR_W-1:0]                       pAdr_out;
  logic [bus_des_pkg::NCHUNK*bus_des_pkg::CHUNK_W-1:0]  data_out;
  logic [3:0]                                           return_out;
  logic                                                 rw_out;
  logic [bus_des_pkg::SIZE_W-1:0]                       size_out;
  logic                                                 taken;
  logic                                                 overrun;

  modport slave (
    input  BUS, taken,
    output free_bau, valid_out, pAdr_out, data_out, return_out, rw_out, size_out, overrun
  );

  modport master (
    output BUS, taken,
    input  free_bau, valid_out, pAdr_out, data_out, return_out, rw_out, size_out, overrun
  );

endinterface

// File: rtl/des_chunk_buf.sv
// 4x32 reassembly bank with one-hot slot writes and a synchronous clear-all.
// A write in the same cycle as a clear lands on top of the cleared bank.
module des_chunk_buf
  import bus_des_pkg::*;
(
  input  logic                        clk_bus,
  input  logic                        rst,
  input  logic                        clr_i,
  input  logic [NCHUNK-1:0]           we_i,
  input  logic [CHUNK_W-1:0]          wdata_i,
  output logic [NCHUNK*CHUNK_W-1:0]   data_o
);

  logic [NCHUNK-1:0][CHUNK_W-1:0] slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (clr_i) slot_d = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (we_i[i]) slot_d[i] = wdata_i;
    end
  end

  always_ff @(posedge clk_bus or negedge rst) begin
    if (!rst) slot_q <= '0;
    else      slot_q <= slot_d;
  end

  assign data_o = slot_q;

endmodule

// File: rtl/bus_des.sv
// Deserializing bus receiver: claims beats addressed to MY_ID, reassembles up to
// four chunks into one packet and holds it until the attached block takes it.
module bus_des
  import bus_des_pkg::*;
#(
  parameter logic [3:0] MY_ID = 4'd0
) (
  input  logic       clk_bus,
  input  logic       rst,
  bus_des_if.slave   bif
);

  des_state_e          state_q, state_d;
  logic [PADR_W-1:0]   padr_q, padr_d;
  logic [3:0]          ret_q, ret_d;
  logic                rw_q, rw_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic                overrun_q, overrun_d;

  logic [SIZE_W-1:0]   beat_size;
  logic                hit;
  logic                buf_clr;
  logic [NCHUNK-1:0]   buf_we;
  logic                unused_size_hi;

  assign beat_size      = bif.BUS[SIZE_HI:SIZE_LO];
  assign unused_size_hi = ^bif.BUS[BUS_W-1:SIZE_HI+1];
  // A zero size field carries no chunk, so it is treated as a non-match everywhere.
  assign hit = bif.BUS[VALID] && (bif.BUS[DEST_HI:DEST_LO] == MY_ID) && (beat_size != '0);

  always_comb begin
    state_d   = state_q;
    padr_d    = padr_q;
    ret_d     = ret_q;
    rw_d      = rw_q;
    size_d    = size_q;
    overrun_d = overrun_q;
    buf_clr   = 1'b0;
    buf_we    = '0;
    unique case (state_q)
      StIdle: begin
        if (hit) begin
          padr_d  = bif.BUS[PADR_HI:PADR_LO];
          ret_d   = bif.BUS[RET_HI:RET_LO];
          rw_d    = bif.BUS[RW];
          size_d  = beat_size;
          buf_clr = 1'b1;
          buf_we  = beat_size;
          state_d = beat_size[0] ? StFull : StRecv;
        end
      end
      StRecv: begin
        if (hit) begin
          buf_we = beat_size;
          if (beat_size[0]) state_d = StFull;
        end
      end
      StFull: begin
        if (hit)       overrun_d = 1'b1;
        if (bif.taken) state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_bus or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      padr_q    <= '0;
      ret_q     <= '0;
      rw_q      <= 1'b0;
      size_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      padr_q    <= padr_d;
      ret_q     <= ret_d;
      rw_q      <= rw_d;
      size_q    <= size_d;
      overrun_q <= overrun_d;
    end
  end

  des_chunk_buf u_chunk_buf (
    .clk_bus (clk_bus),
    .rst     (rst),
    .clr_i   (buf_clr),
    .we_i    (buf_we),
    .wdata_i (bif.BUS[DATA_HI:DATA_LO]),
    .data_o  (bif.data_out)
  );

  assign bif.free_bau   = (state_q == StIdle);
  assign bif.valid_out  = (state_q == StFull);
  assign bif.pAdr_out   = padr_q;
  assign bif.return_out = ret_q;
  assign bif.rw_out     = rw_q;
  assign bif.size_out   = size_q;
  assign bif.overrun    = overrun_q;

endmodule

// File: tb/tb_bus_des.sv
// Self-checking bench for bus_des with MY_ID=3: expected packets are queued as
// beats are driven and compared when the receiver presents valid_out.
module tb_bus_des;

  typedef struct packed {
    logic [127:0] data;
    logic [14:0]  padr;
    logic [3:0]   ret;
    logic         rw;
    logic [3:0]   size;
  } pkt_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  pkt_t exp_q[$];

  bus_des_if bif();

  bus_des #(.MY_ID(4'd3)) dut (
    .clk_bus (clk),
    .rst     (rst_n),
    .bif     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one bus cycle from a falling edge; returns on the next falling edge.
  task automatic beat(input bit v, input logic [3:0] dest, input logic [3:0] size,
                      input logic [31:0] d, input logic [14:0] padr, input logic [3:0] ret,
                      input logic rw);
    logic [72:0] w;
    w        = '0;
    w[72:61] = 12'($urandom);
    w[60:57] = size;
    w[56]    = rw;
    w[55:52] = dest;
    w[51:48] = ret;
    w[47:16] = d;
    w[15:1]  = padr;
    w[0]     = v;
    bif.BUS  = w;
    @(negedge clk);
  endtask

  task automatic bus_idle();
    bif.BUS = '0;
  endtask

  task automatic check_packet(input string tag);
    pkt_t e;
    int   n;
    n = 0;
    while (!bif.valid_out && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 128'(bif.valid_out), 128'd1);
    check({tag, "_sb_has_entry"}, 128'(exp_q.size() != 0), 128'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_data"}, bif.data_out, e.data);
      check({tag, "_padr"}, 128'(bif.pAdr_out), 128'(e.padr));
      check({tag, "_ret"}, 128'(bif.return_out), 128'(e.ret));
      check({tag, "_rw"}, 128'(bif.rw_out), 128'(e.rw));
      check({tag, "_size"}, 128'(bif.size_out), 128'(e.size));
    end
  endtask

  task automatic release_pkt(input string tag);
    bif.taken = 1'b1;
    @(negedge clk);
    bif.taken = 1'b0;
    check({tag, "_rel_valid"}, 128'(bif.valid_out), 128'd0);
    check({tag, "_rel_free"}, 128'(bif.free_bau), 128'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    bif.BUS   = '0;
    bif.taken = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 128'(bif.valid_out), 128'd0);
    check("rst_free", 128'(bif.free_bau), 128'd1);
    check("rst_overrun", 128'(bif.overrun), 128'd0);
    check("rst_data", bif.data_out, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Four-chunk transfer; later beats carry a different header that must be ignored.
    exp_q.push_back('{128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000, 15'h1234, 4'h5, 1'b1, 4'b1000});
    beat(1, 4'd3, 4'b1000, 32'hAAAA0003, 15'h1234, 4'h5, 1'b1);
    check("t1_busy", 128'(bif.free_bau), 128'd0);
    beat(1, 4'd3, 4'b0100, 32'hAAAA0002, 15'h7FFF, 4'hF, 1'b0);
    beat(1, 4'd3, 4'b0010, 32'hAAAA0001, 15'h7FFF, 4'hF, 1'b0);
    check("t1_not_early", 128'(bif.valid_out), 128'd0);
    beat(1, 4'd3, 4'b0001, 32'hAAAA0000, 15'h7FFF, 4'hF, 1'b0);
    check("t1_latency", 128'(bif.valid_out), 128'd1);
    bus_idle();
    check_packet("t1");
    release_pkt("t1");

    // Single chunk; upper slots must be cleared from the previous packet.
    exp_q.push_back('{{96'd0, 32'hDEADBEEF}, 15'h0007, 4'hA, 1'b0, 4'b0001});
    beat(1, 4'd3, 4'b0001, 32'hDEADBEEF, 15'h0007, 4'hA, 1'b0);
    check("t2_latency", 128'(bif.valid_out), 128'd1);
    bus_idle();
    check_packet("t2");
    release_pkt("t2");

    // Address filter with foreign beats and valid=0 gaps interleaved.
    exp_q.push_back('{128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000, 15'h1234, 4'h5, 1'b1, 4'b1000});
    beat(1, 4'd3, 4'b1000, 32'hAAAA0003, 15'h1234, 4'h5, 1'b1);
    beat(1, 4'd2, 4'b0001, 32'hBBBB0000, 15'h0001, 4'h1, 1'b0);
    beat(0, 4'd3, 4'b0100, 32'hCCCC0002, 15'h0002, 4'h2, 1'b0);
    beat(1, 4'd3, 4'b0100, 32'hAAAA0002, 15'h1234, 4'h5, 1'b1);
    bus_idle();
    @(negedge clk);
    beat(1, 4'd2, 4'b0010, 32'hBBBB0001, 15'h0003, 4'h3, 1'b0);
    beat(1, 4'd3, 4'b0010, 32'hAAAA0001, 15'h1234, 4'h5, 1'b1);
    beat(0, 4'd3, 4'b0001, 32'hCCCC0000, 15'h0004, 4'h4, 1'b0);
    check("t3_no_false_end", 128'(bif.valid_out), 128'd0);
    beat(1, 4'd3, 4'b0001, 32'hAAAA0000, 15'h1234, 4'h5, 1'b1);
    bus_idle();
    check_packet("t3");
    release_pkt("t3");

    // Overrun while holding the packet.
    exp_q.push_back('{{96'd0, 32'h11111111}, 15'h0011, 4'h1, 1'b1, 4'b0001});
    beat(1, 4'd3, 4'b0001, 32'h11111111, 15'h0011, 4'h1, 1'b1);
    beat(1, 4'd3, 4'b0001, 32'h22222222, 15'h0022, 4'h2, 1'b0);
    bus_idle();
    check("t4_overrun", 128'(bif.overrun), 128'd1);
    check_packet("t4");
    release_pkt("t4");
    check("t4_overrun_sticky", 128'(bif.overrun), 128'd1);
    rst_n = 1'b0;
    #1;
    check("t4_rst_clears_ovr", 128'(bif.overrun), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Overrun on the same cycle taken is asserted: beat still dropped.
    exp_q.push_back('{{96'd0, 32'h33333333}, 15'h0033, 4'h3, 1'b0, 4'b0001});
    beat(1, 4'd3, 4'b0001, 32'h33333333, 15'h0033, 4'h3, 1'b0);
    bus_idle();
    check_packet("t4b");
    bif.taken = 1'b1;
    beat(1, 4'd3, 4'b0001, 32'h44444444, 15'h0044, 4'h4, 1'b1);
    bif.taken = 1'b0;
    bus_idle();
    check("t4b_overrun", 128'(bif.overrun), 128'd1);
    check("t4b_valid", 128'(bif.valid_out), 128'd0);
    check("t4b_free", 128'(bif.free_bau), 128'd1);
    check("t4b_data_kept", bif.data_out, {96'd0, 32'h33333333});
    @(negedge clk);
    check("t4b_no_capture", 128'(bif.valid_out), 128'd0);

    // Asynchronous reset in the middle of a transfer.
    beat(1, 4'd3, 4'b1000, 32'h99990003, 15'h0099, 4'h9, 1'b1);
    beat(1, 4'd3, 4'b0100, 32'h99990002, 15'h0099, 4'h9, 1'b1);
    bus_idle();
    #2 rst_n = 1'b0;
    #1;
    check("t5_data", bif.data_out, 128'd0);
    check("t5_free", 128'(bif.free_bau), 128'd1);
    check("t5_valid", 128'(bif.valid_out), 128'd0);
    check("t5_padr", 128'(bif.pAdr_out), 128'd0);
    check("t5_size", 128'(bif.size_out), 128'd0);
    check("t5_overrun", 128'(bif.overrun), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back('{{64'd0, 32'h55555555, 32'h66666666}, 15'h0555, 4'h6, 1'b1, 4'b0010});
    beat(1, 4'd3, 4'b0010, 32'h55555555, 15'h0555, 4'h6, 1'b1);
    beat(1, 4'd3, 4'b0001, 32'h66666666, 15'h0555, 4'h6, 1'b1);
    bus_idle();
    check_packet("t5");
    release_pkt("t5");

    // Zero size field in IDLE: ignored entirely.
    beat(1, 4'd3, 4'b0000, 32'h77777777, 15'h0ABC, 4'h7, 1'b0);
    bus_idle();
    check("t6_free", 128'(bif.free_bau), 128'd1);
    check("t6_valid", 128'(bif.valid_out), 128'd0);
    check("t6_overrun", 128'(bif.overrun), 128'd0);
    check("t6_padr", 128'(bif.pAdr_out), 128'(15'h0555));
    check("t6_sb_drained", 128'(exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
